// File: rtl/sec_mon_pkg.sv
// sec_mon_pkg: shared states, error codes and width defaults for the graph loader
package sec_mon_pkg;
  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;
  localparam logic [3:0] WE_ALL = 4'hF;
  localparam logic [1:0] ERR_OK     = 2'd0;
  localparam logic [1:0] ERR_RANGE  = 2'd1;
  localparam logic [1:0] ERR_ABORT  = 2'd2;
  localparam logic [1:0] ERR_VERIFY = 2'd3;
  typedef enum logic [2:0] {IDLE, CHK, LOAD_BB, LOAD_NH, VERIFY, DONE} state_e;
endpackage

// File: rtl/sec_graph_sig.sv
// sec_graph_sig: rotate-left/XOR signature of words written to one RAM versus words read back
module sec_graph_sig #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              match_o
);
  logic [DATA_W-1:0] wr_sig_q, wr_sig_d, rd_sig_q, rd_sig_d;
  // fold each word into its signature; an accepted start clears both
  always_comb begin
    wr_sig_d = clr_i ? '0 : wr_en_i ? {wr_sig_q[DATA_W-2:0], wr_sig_q[DATA_W-1]} ^ wr_data_i : wr_sig_q;
    rd_sig_d = clr_i ? '0 : rd_en_i ? {rd_sig_q[DATA_W-2:0], rd_sig_q[DATA_W-1]} ^ rd_data_i : rd_sig_q;
  end
  // signature registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_sig_q <= '0;
      rd_sig_q <= '0;
    end else begin
      wr_sig_q <= wr_sig_d;
      rd_sig_q <= rd_sig_d;
    end
  end
  assign match_o = wr_sig_q == rd_sig_q;
endmodule

// File: rtl/sec_graph_loader.sv
// sec_graph_loader: writes streamed words into the basic-block and next-hop RAMs; SEC_GRAPH_VERIFY_EN adds read-back verify
module sec_graph_loader
  import sec_mon_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 12
) (
  input  logic              core_sp_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_idx,
  input  logic [CNT_W-1:0]  num_entries,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] bbr_addr,
  output logic [DATA_W-1:0] bbr_data_in,
  output logic [3:0]        bbr_we,
  output logic [ADDR_W-1:0] nhr_addr,
  output logic [DATA_W-1:0] nhr_data_in,
  output logic [3:0]        nhr_we,
  input  logic [DATA_W-1:0] bbr_data_out,
  input  logic [DATA_W-1:0] nhr_data_out,
  output logic              monitor_hold,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code
);
  localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(2**ADDR_W);
  state_e            state_q, state_d;
  logic [1:0]        err_q, err_d, flush_q, flush_d;
  logic [ADDR_W-1:0] base_q, base_d, idx_q, idx_d, bb_addr_q, bb_addr_d, nh_addr_q, nh_addr_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W:0]    cnt_q, cnt_d, num_ext, end_ext;
  logic [DATA_W-1:0] bb_data_q, bb_data_d, nh_data_q, nh_data_d;
  logic [3:0]        bb_we_q, bb_we_d, nh_we_q, nh_we_d;
  logic              hs, last, range_bad;
  assign num_ext   = {1'b0, num_q};
  assign end_ext   = (CNT_W+1)'(base_q) + num_ext;
  assign range_bad = (num_q == '0) || (end_ext > LIMIT);
  assign wr_ready  = ((state_q == LOAD_BB) || (state_q == LOAD_NH)) && !abort;
  assign hs        = wr_valid && wr_ready;
  assign last      = (cnt_q + (CNT_W+1)'(1)) == num_ext;
`ifdef SEC_GRAPH_VERIFY_EN
  localparam state_e AFTER_LOAD = VERIFY;
  logic rv1_q, rv2_q, bb_ok, nh_ok, sig_clr, rd_issue, verify_end;
  assign sig_clr    = (state_q == IDLE) && start;
  assign rd_issue   = (state_q == VERIFY) && (cnt_q < num_ext);
  assign verify_end = cnt_q == num_ext + (CNT_W+1)'(2);
  // read-data valid follows the address register, then the RAM's own read register
  always_ff @(posedge core_sp_clk or negedge reset_n) begin
    if (!reset_n) begin
      rv1_q <= 1'b0;
      rv2_q <= 1'b0;
    end else begin
      rv1_q <= rd_issue;
      rv2_q <= rv1_q;
    end
  end
  sec_graph_sig #(.DATA_W(DATA_W)) u_bb_sig (
    .clk_i(core_sp_clk), .rst_ni(reset_n), .clr_i(sig_clr),
    .wr_en_i(hs && (state_q == LOAD_BB)), .wr_data_i(wr_data),
    .rd_en_i(rv2_q), .rd_data_i(bbr_data_out), .match_o(bb_ok)
  );
  sec_graph_sig #(.DATA_W(DATA_W)) u_nh_sig (
    .clk_i(core_sp_clk), .rst_ni(reset_n), .clr_i(sig_clr),
    .wr_en_i(hs && (state_q == LOAD_NH)), .wr_data_i(wr_data),
    .rd_en_i(rv2_q), .rd_data_i(nhr_data_out), .match_o(nh_ok)
  );
`else
  localparam state_e AFTER_LOAD = DONE;
  logic unused_rd;
  assign unused_rd = ^{bbr_data_out, nhr_data_out};
`endif
  // next state, error code and next RAM port values; abort overrides every busy state but DONE
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    base_d    = base_q;
    num_d     = num_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    flush_d   = (flush_q != 2'd0) ? flush_q - 2'd1 : 2'd0;
    bb_addr_d = bb_addr_q;
    bb_data_d = bb_data_q;
    bb_we_d   = '0;
    nh_addr_d = nh_addr_q;
    nh_data_d = nh_data_q;
    nh_we_d   = '0;
    case (state_q)
      IDLE: if (start) begin
        state_d = CHK;
        err_d   = ERR_OK;
        base_d  = base_idx;
        num_d   = num_entries;
        idx_d   = base_idx;
        cnt_d   = '0;
      end
      CHK: begin
        state_d = range_bad ? DONE : LOAD_BB;
        err_d   = range_bad ? ERR_RANGE : err_q;
      end
      LOAD_BB: if (hs) begin
        bb_addr_d = idx_q;
        bb_data_d = wr_data;
        bb_we_d   = WE_ALL;
        state_d   = LOAD_NH;
      end
      LOAD_NH: if (hs) begin
        nh_addr_d = idx_q;
        nh_data_d = wr_data;
        nh_we_d   = WE_ALL;
        idx_d     = last ? base_q : idx_q + ADDR_W'(1);
        cnt_d     = last ? '0 : cnt_q + (CNT_W+1)'(1);
        state_d   = last ? AFTER_LOAD : LOAD_BB;
      end
      VERIFY: begin
`ifdef SEC_GRAPH_VERIFY_EN
        bb_addr_d = rd_issue ? idx_q : bb_addr_q;
        nh_addr_d = rd_issue ? idx_q : nh_addr_q;
        idx_d     = rd_issue ? idx_q + ADDR_W'(1) : idx_q;
        cnt_d     = cnt_q + (CNT_W+1)'(1);
        state_d   = verify_end ? DONE : VERIFY;
        err_d     = (verify_end && !(bb_ok && nh_ok)) ? ERR_VERIFY : err_q;
`else
        state_d = DONE;
`endif
      end
      DONE: begin
        state_d = IDLE;
        flush_d = 2'd2;
      end
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE) && (state_q != DONE)) begin
      state_d = DONE;
      err_d   = ERR_ABORT;
    end
  end
  // state, latched request and registered RAM ports
  always_ff @(posedge core_sp_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      err_q     <= ERR_OK;
      flush_q   <= 2'd0;
      base_q    <= '0;
      num_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      bb_addr_q <= '0;
      bb_data_q <= '0;
      bb_we_q   <= '0;
      nh_addr_q <= '0;
      nh_data_q <= '0;
      nh_we_q   <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      flush_q   <= flush_d;
      base_q    <= base_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      bb_addr_q <= bb_addr_d;
      bb_data_q <= bb_data_d;
      bb_we_q   <= bb_we_d;
      nh_addr_q <= nh_addr_d;
      nh_data_q <= nh_data_d;
      nh_we_q   <= nh_we_d;
    end
  end
  assign bbr_addr     = bb_addr_q;
  assign bbr_data_in  = bb_data_q;
  assign bbr_we       = bb_we_q;
  assign nhr_addr     = nh_addr_q;
  assign nhr_data_in  = nh_data_q;
  assign nhr_we       = nh_we_q;
  assign busy         = state_q != IDLE;
  assign done         = state_q == DONE;
  assign monitor_hold = busy || (flush_q != 2'd0);
  assign err_code     = err_q;
endmodule

// File: tb/tb_sec_graph_loader.sv
// tb_sec_graph_loader: randomized loads checked against an entry-level model of the expected RAM writes
module tb_sec_graph_loader;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int CW = 12;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_idx = '0;
  logic [CW-1:0] num_entries = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready, monitor_hold, busy, done;
  logic [AW-1:0] bbr_addr, nhr_addr;
  logic [DW-1:0] bbr_data_in, nhr_data_in;
  logic [DW-1:0] bbr_data_out = '0;
  logic [DW-1:0] nhr_data_out = '0;
  logic [3:0]    bbr_we, nhr_we;
  logic [1:0]    err_code;
  logic [127:0]  outs;
  int            tests = 0;
  int            fails = 0;
  bit            corrupt = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic [DW-1:0] bb_mem [0:2047];
  logic [DW-1:0] nh_mem [0:2047];
  typedef struct packed {logic [3:0] we; logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t bb_q[$];
  wr_t nh_q[$];

  sec_graph_loader dut (
    .core_sp_clk(clk), .reset_n(rst_n), .start(start), .abort(abort),
    .base_idx(base_idx), .num_entries(num_entries), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .bbr_addr(bbr_addr),
    .bbr_data_in(bbr_data_in), .bbr_we(bbr_we), .nhr_addr(nhr_addr),
    .nhr_data_in(nhr_data_in), .nhr_we(nhr_we), .bbr_data_out(bbr_data_out),
    .nhr_data_out(nhr_data_out), .monitor_hold(monitor_hold), .busy(busy),
    .done(done), .err_code(err_code)
  );

  always #5 clk = ~clk;

  assign outs = 128'({wr_ready, bbr_addr, bbr_data_in, bbr_we, nhr_addr, nhr_data_in, nhr_we,
                      monitor_hold, busy, done, err_code});

  // synchronous RAMs with one-cycle read latency; corruption flips bit 0 of one next-hop read
  always @(posedge clk) begin
    if (bbr_we == 4'hF) bb_mem[bbr_addr] <= bbr_data_in;
    if (nhr_we == 4'hF) nh_mem[nhr_addr] <= nhr_data_in;
    bbr_data_out <= bb_mem[bbr_addr];
    nhr_data_out <= nh_mem[nhr_addr] ^ ((corrupt && nhr_addr == corrupt_addr) ? 32'h1 : 32'h0);
  end

  // record every cycle that carries a write enable
  always @(negedge clk) begin
    if (bbr_we != 4'h0) bb_q.push_back({bbr_we, bbr_addr, bbr_data_in});
    if (nhr_we != 4'h0) nh_q.push_back({nhr_we, nhr_addr, nhr_data_in});
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one load: 2n random words, optional abort on handshake abort_at, random gaps plus one forced gap
  task automatic run_load(input int base, input int n, input int abort_at, input int gap_pct,
                          input int gap_k, input int gap_len, input bit corrupt_en);
    logic [DW-1:0] w[$];
    wr_t           e;
    int            exp_err, h, k, cyc, gl;
    bit            seen, aborted;
    logic [1:0]    got_err;
    bb_q.delete();
    nh_q.delete();
    for (int i = 0; i < 2 * n; i++) w.push_back($urandom);
    exp_err = (n == 0 || base + n > 2048) ? 1 : (abort_at >= 0 && abort_at < 2 * n) ? 2 : corrupt_en ? 3 : 0;
    h = exp_err == 1 ? 0 : exp_err == 2 ? abort_at : 2 * n;
    corrupt = corrupt_en;
    corrupt_addr = AW'(base + 1);
    @(posedge clk); #1;
    start = 1'b1;
    base_idx = AW'(base);
    num_entries = CW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; cyc = 0; gl = gap_len; seen = 0; aborted = 0; got_err = 2'd0;
    while (!seen && cyc < 100 + 20 * n) begin
      if (k == gap_k && gl > 0) begin
        wr_valid = 1'b0;
        gl--;
      end else wr_valid = (k < 2 * n) && !aborted && ($urandom_range(99) >= gap_pct);
      wr_data = (k < 2 * n) ? w[k] : $urandom;
      abort = wr_valid && (k == abort_at);
      @(negedge clk);
      if (abort) check("ready_on_abort", wr_ready, 0);
      if (done) begin
        seen = 1;
        got_err = err_code;
        check("hold_at_done", monitor_hold, 1);
      end else if (abort) aborted = 1;
      else if (wr_valid && wr_ready) k++;
      @(posedge clk); #1;
      abort = 1'b0;
      cyc++;
    end
    wr_valid = 1'b0;
    check("done_seen", seen, 1);
    check("err_code", got_err, exp_err);
    if (exp_err == 1) check("range_latency_ok", cyc <= 2, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("hold_flush1", monitor_hold, 1);
    @(negedge clk);
    check("hold_flush2", monitor_hold, 1);
    @(negedge clk);
    check("hold_released", {monitor_hold, busy}, 0);
    @(posedge clk); #1;
    check("bb_count", bb_q.size(), (h + 1) / 2);
    check("nh_count", nh_q.size(), h / 2);
    for (int i = 0; i < (h + 1) / 2 && i < bb_q.size(); i++) begin
      e = {4'hF, AW'(base + i), w[2 * i]};
      check("bb_write", bb_q[i], e);
    end
    for (int i = 0; i < h / 2 && i < nh_q.size(); i++) begin
      e = {4'hF, AW'(base + i), w[2 * i + 1]};
      check("nh_write", nh_q[i], e);
    end
    corrupt = 1'b0;
  endtask

  initial begin
    int k, cyc, n, base;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs, 0);
    rst_n = 1'b1;
    run_load(0, 2, -1, 0, -1, 0, 0);
    run_load(2047, 2, -1, 0, -1, 0, 0);
    run_load(5, 0, -1, 0, -1, 0, 0);
    run_load(2046, 2, -1, 0, -1, 0, 0);
    run_load(40, 4, -1, 0, 3, 5, 0);
    run_load(0, 4, 2, 0, -1, 0, 0);
    @(posedge clk); #1;
    start = 1'b1;
    base_idx = AW'(10);
    num_entries = CW'(4);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; cyc = 0;
    while (k < 3 && cyc < 50) begin
      wr_valid = 1'b1;
      wr_data = $urandom;
      @(negedge clk);
      if (wr_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    wr_valid = 1'b0;
    check("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", outs, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_load(10, 4, -1, 20, -1, 0, 0);
`ifdef SEC_GRAPH_VERIFY_EN
    run_load(100, 4, -1, 0, -1, 0, 1);
    run_load(100, 4, -1, 0, -1, 0, 0);
`endif
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 6);
      base = $urandom_range(2048 - n);
      run_load(base, n, ($urandom_range(3) == 0) ? int'($urandom_range(2 * n - 1)) : -1, 30, -1, 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
